// File: rtl/branch_predict_unit.sv
// EX-stage branch resolution plus a direct-mapped BTB with saturating counters.
// The BTB is looked up in IF and trained in EX. Statistics counters saturate.
module branch_predict_unit #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 64,
    parameter int CTR_W   = 2,
    parameter int STAT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [XLEN-1:0]   PCF,
    output logic              PredTakenF,
    output logic [XLEN-1:0]   PredTargetF,
    input  logic              ValidE,
    input  logic [XLEN-1:0]   PCE,
    input  logic [2:0]        BranchTypeE,
    input  logic [XLEN-1:0]   Operand1,
    input  logic [XLEN-1:0]   Operand2,
    input  logic [XLEN-1:0]   BrTargetE,
    input  logic              PredTakenE,
    input  logic [XLEN-1:0]   PredTargetE,
    output logic              BranchE,
    output logic              MispredE,
    output logic [XLEN-1:0]   RedirectPCE,
    output logic [STAT_W-1:0] BranchCnt,
    output logic [STAT_W-1:0] MispredCnt
);
    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX - 2;

    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BR_BEQ  = 3'd1;
    localparam logic [2:0] BR_BNE  = 3'd2;
    localparam logic [2:0] BR_BLT  = 3'd3;
    localparam logic [2:0] BR_BLTU = 3'd4;
    localparam logic [2:0] BR_BGE  = 3'd5;
    localparam logic [2:0] BR_BGEU = 3'd6;

    localparam logic [CTR_W-1:0] CTR_MAX = '1;
    localparam logic [CTR_W-1:0] CTR_WT  = {1'b1, {(CTR_W-1){1'b0}}};
    localparam logic [CTR_W-1:0] CTR_WNT = {1'b0, {(CTR_W-1){1'b1}}};

    logic              valid_tbl  [ENTRIES];
    logic [TAG_W-1:0]  tag_tbl    [ENTRIES];
    logic [XLEN-1:0]   target_tbl [ENTRIES];
    logic [CTR_W-1:0]  ctr_tbl    [ENTRIES];

    logic [IDX-1:0]    idx_f;
    logic [IDX-1:0]    idx_e;
    logic [TAG_W-1:0]  tag_f;
    logic [TAG_W-1:0]  tag_e;
    logic              hit_f;
    logic              hit_e;
    logic              br;

    // Instructions are word aligned, so the low PC bits carry no information.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{PCF[1:0], PCE[1:0]};

    assign idx_f = PCF[IDX+1:2];
    assign tag_f = PCF[XLEN-1:IDX+2];
    assign idx_e = PCE[IDX+1:2];
    assign tag_e = PCE[XLEN-1:IDX+2];

    assign hit_f       = valid_tbl[idx_f] && (tag_tbl[idx_f] == tag_f);
    assign hit_e       = valid_tbl[idx_e] && (tag_tbl[idx_e] == tag_e);
    assign PredTakenF  = hit_f && ctr_tbl[idx_f][CTR_W-1];
    assign PredTargetF = PredTakenF ? target_tbl[idx_f] : '0;

    always_comb begin
        BranchE = 1'b0;
        br      = 1'b0;
        case (BranchTypeE)
            BR_BEQ:  begin br = ValidE; BranchE = (Operand1 == Operand2); end
            BR_BNE:  begin br = ValidE; BranchE = (Operand1 != Operand2); end
            BR_BLT:  begin br = ValidE; BranchE = ($signed(Operand1) <  $signed(Operand2)); end
            BR_BLTU: begin br = ValidE; BranchE = (Operand1 <  Operand2); end
            BR_BGE:  begin br = ValidE; BranchE = ($signed(Operand1) >= $signed(Operand2)); end
            BR_BGEU: begin br = ValidE; BranchE = (Operand1 >= Operand2); end
            default: begin br = 1'b0;   BranchE = 1'b0; end
        endcase
    end

    // A predicted-taken non-branch means the BTB entry is stale.
    assign MispredE = (br && (BranchE != PredTakenE))
                   || (br && BranchE && PredTakenE && (PredTargetE != BrTargetE))
                   || (ValidE && !br && PredTakenE);

    assign RedirectPCE = (BranchE && br) ? BrTargetE : PCE + XLEN'(4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_tbl[i]  <= 1'b0;
                tag_tbl[i]    <= '0;
                target_tbl[i] <= '0;
                ctr_tbl[i]    <= CTR_WNT;
            end
        end else if (ValidE) begin
            if (br && BranchE) begin
                target_tbl[idx_e] <= BrTargetE;
                if (hit_e) begin
                    if (ctr_tbl[idx_e] != CTR_MAX)
                        ctr_tbl[idx_e] <= ctr_tbl[idx_e] + CTR_W'(1);
                end else begin
                    valid_tbl[idx_e] <= 1'b1;
                    tag_tbl[idx_e]   <= tag_e;
                    ctr_tbl[idx_e]   <= CTR_WT;
                end
            end else if (br && hit_e) begin
                if (ctr_tbl[idx_e] != '0)
                    ctr_tbl[idx_e] <= ctr_tbl[idx_e] - CTR_W'(1);
            end else if (!br && PredTakenE && hit_e) begin
                valid_tbl[idx_e] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            BranchCnt  <= '0;
            MispredCnt <= '0;
        end else begin
            if (br && (BranchCnt != '1))
                BranchCnt <= BranchCnt + STAT_W'(1);
            if (MispredE && (MispredCnt != '1))
                MispredCnt <= MispredCnt + STAT_W'(1);
        end
    end
endmodule
